// File: rtl/jtframe_mcu_pkg.sv
// Shared definitions for the MCU program-ROM responder.
//   state_t  : responder FSM encoding (IDLE, REQ, WAIT)
//   line_t   : one line-buffer record {valid, tag, data}; the tag field is
//              sized for the widest supported ROM and holds the word tag
//              zero-extended
//   byte_sel : little-endian byte pick from a 32-bit word
package jtframe_mcu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int LINE_TAGW = 30;

  typedef struct packed {
    logic                 valid;
    logic [LINE_TAGW-1:0] tag;
    logic [31:0]          data;
  } line_t;

  // Byte n of the word lives in bits [8n+7:8n].
  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jtframe_mcu_romline.sv
// One 32-bit line buffer of the MCU ROM responder: stores a word and its tag,
// compares the tag against the current ROM byte address and picks the byte.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset (line invalid)
//   i_we                  write the line (sets valid)
//   i_wr_tag, i_wr_data   word tag and word written on i_we
//   i_addr                current ROM byte address
//   o_hit                 line valid and tag matches i_addr[ROMW-1:2]
//   o_byte                byte i_addr[1:0] of the stored word
//   o_data                stored word (used to move a line into another)
module jtframe_mcu_romline
  import jtframe_mcu_pkg::*;
#(
  parameter int ROMW = 12
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [ROMW-3:0] i_wr_tag,
  input  logic [31:0]     i_wr_data,
  input  logic [ROMW-1:0] i_addr,
  output logic            o_hit,
  output logic [7:0]      o_byte,
  output logic [31:0]     o_data
);

  line_t r_line;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_line <= '0;
    end else if (i_we) begin
      r_line.valid <= 1'b1;
      r_line.tag   <= LINE_TAGW'(i_wr_tag);
      r_line.data  <= i_wr_data;
    end
  end

  assign o_hit  = r_line.valid && (r_line.tag == LINE_TAGW'(i_addr[ROMW-1:2]));
  assign o_byte = byte_sel(r_line.data, i_addr[1:0]);
  assign o_data = r_line.data;

endmodule

// File: rtl/jtframe_mcu_romrsp.sv
// Responder side of the MCU program-ROM bus. Serves byte fetches from a
// one-word line buffer and refills it from one SDRAM request slot.
// Optional feature macro: JTFRAME_MCU_ROMRSP_PREFETCH_EN adds a second line
// that speculatively fetches the word after the current one.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_rom_cs          MCU requests the byte at i_rom_addr
//   i_rom_addr        ROM byte address (ROMW bits)
//   o_rom_data        byte at i_rom_addr while o_rom_ok, else last hit byte
//   o_rom_ok          combinational: i_rom_cs and the address hits a line
//   o_sdram_req       word request, held until i_sdram_ack
//   o_sdram_addr      OFFSET + word tag, modulo 2^SDRAMW
//   i_sdram_ack       request accepted (1-cycle pulse)
//   i_sdram_dst       i_sdram_data valid (1-cycle pulse)
//   i_sdram_data      little-endian 32-bit word
//   o_dbg_state       current FSM state
//
// SDRAM handshake: o_sdram_req/o_sdram_addr are stable from the cycle the
// request appears until the cycle i_sdram_ack is seen high; req drops on that
// edge. Data is taken on the first i_sdram_dst at or after the ack cycle
// (same-cycle ack+dst is a complete transaction). Only one request is ever
// outstanding, and an accepted request always completes and fills, even if
// the MCU has moved to another address.
module jtframe_mcu_romrsp
  import jtframe_mcu_pkg::*;
#(
  parameter int                ROMW   = 12,
  parameter int                SDRAMW = 22,
  parameter logic [SDRAMW-1:0] OFFSET = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rom_cs,
  input  logic [ROMW-1:0]   i_rom_addr,
  output logic [7:0]        o_rom_data,
  output logic              o_rom_ok,
  output logic              o_sdram_req,
  output logic [SDRAMW-1:0] o_sdram_addr,
  input  logic              i_sdram_ack,
  input  logic              i_sdram_dst,
  input  logic [31:0]       i_sdram_data,
  output state_t            o_dbg_state
);

  localparam int TAGW = ROMW - 2;

  state_t            r_state, w_state_nx;
  logic              w_start, w_fill;
  logic              r_req;
  logic [SDRAMW-1:0] r_addr;
  logic [TAGW-1:0]   r_tag;
  logic [7:0]        r_last;

  logic [TAGW-1:0]   w_rom_tag, w_start_tag, w_main_tag;
  logic              w_hit_main, w_hit_any, w_miss, w_start_pf, w_main_we;
  logic [7:0]        w_byte_main, w_byte;
  logic [31:0]       w_main_wdata, w_unused_main_data;

  assign w_rom_tag = i_rom_addr[ROMW-1:2];

`ifdef JTFRAME_MCU_ROMRSP_PREFETCH_EN
  logic            r_kind_pf, r_pf_pend;
  logic [TAGW-1:0] r_pf_tag;
  logic            w_hit_pf, w_promote, w_fill_main, w_fill_pf;
  logic [7:0]      w_byte_pf;
  logic [31:0]     w_pf_data;

  assign w_fill_main = w_fill && !r_kind_pf;
  assign w_fill_pf   = w_fill && r_kind_pf;
  assign w_hit_any   = w_hit_main || w_hit_pf;
  assign w_byte      = w_hit_main ? w_byte_main : w_byte_pf;
  assign w_miss      = i_rom_cs && !w_hit_any;
  // A demand fill of the main line takes precedence over promotion.
  assign w_promote   = i_rom_cs && w_hit_pf && !w_hit_main && !w_fill_main;
  // Demand misses always go first; a promotion re-targets the prefetch, so
  // the stale pending tag is not issued in that cycle.
  assign w_start_pf  = r_pf_pend && !w_miss && !w_promote;
  assign w_start_tag = w_miss ? w_rom_tag : r_pf_tag;
  assign w_main_we   = w_fill_main || w_promote;
  assign w_main_tag  = w_fill_main ? r_tag : w_rom_tag;
  assign w_main_wdata = w_fill_main ? i_sdram_data : w_pf_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_kind_pf <= 1'b0;
      r_pf_pend <= 1'b0;
      r_pf_tag  <= '0;
    end else begin
      if (w_start) r_kind_pf <= !w_miss;
      if (w_fill_main) begin
        r_pf_pend <= 1'b1;
        r_pf_tag  <= r_tag + 1'b1;
      end else if (w_promote) begin
        r_pf_pend <= 1'b1;
        r_pf_tag  <= w_rom_tag + 1'b1;
      end else if (w_start && !w_miss) begin
        r_pf_pend <= 1'b0;
      end
    end
  end

  jtframe_mcu_romline #(.ROMW(ROMW)) u_line_pf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (w_fill_pf),
    .i_wr_tag  (r_tag),
    .i_wr_data (i_sdram_data),
    .i_addr    (i_rom_addr),
    .o_hit     (w_hit_pf),
    .o_byte    (w_byte_pf),
    .o_data    (w_pf_data)
  );
`else
  assign w_hit_any    = w_hit_main;
  assign w_byte       = w_byte_main;
  assign w_miss       = i_rom_cs && !w_hit_main;
  assign w_start_pf   = 1'b0;
  assign w_start_tag  = w_rom_tag;
  assign w_main_we    = w_fill;
  assign w_main_tag   = r_tag;
  assign w_main_wdata = i_sdram_data;
`endif

  jtframe_mcu_romline #(.ROMW(ROMW)) u_line_main (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (w_main_we),
    .i_wr_tag  (w_main_tag),
    .i_wr_data (w_main_wdata),
    .i_addr    (i_rom_addr),
    .o_hit     (w_hit_main),
    .o_byte    (w_byte_main),
    .o_data    (w_unused_main_data)
  );

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_fill     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss || w_start_pf) begin
          w_start    = 1'b1;
          w_state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_sdram_ack) begin
          if (i_sdram_dst) begin
            w_fill     = 1'b1;
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_sdram_dst) begin
          w_fill     = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_tag   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_start) begin
        r_req  <= 1'b1;
        r_tag  <= w_start_tag;
        r_addr <= OFFSET + SDRAMW'(w_start_tag);
      end else if (r_state == ST_REQ && i_sdram_ack) begin
        r_req <= 1'b0;
      end
      // rom_data keeps the last hit byte while the address misses.
      if (w_hit_any) r_last <= w_byte;
    end
  end

  assign o_rom_ok     = i_rom_cs && w_hit_any;
  assign o_rom_data   = w_hit_any ? w_byte : r_last;
  assign o_sdram_req  = r_req;
  assign o_sdram_addr = r_addr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_jtframe_mcu_romrsp.sv
// Bench for jtframe_mcu_romrsp: directed handshake/timing cases, then a
// random fetch stream served by a bench-side SDRAM responder with random
// ack/data latencies. Expected bytes are queued when a fetch is driven and
// compared when rom_ok appears.
module tb_jtframe_mcu_romrsp;
  import jtframe_mcu_pkg::*;

  localparam int ROMW   = 12;
  localparam int SDRAMW = 22;
  localparam logic [SDRAMW-1:0] OFFSET = 22'h3FFC01;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rom_cs = 1'b0;
  logic [ROMW-1:0]   rom_addr = '0;
  logic [7:0]        rom_data;
  logic              rom_ok;
  logic              sdram_req;
  logic [SDRAMW-1:0] sdram_addr;
  logic              sdram_ack = 1'b0;
  logic              sdram_dst = 1'b0;
  logic [31:0]       sdram_data = '0;
  state_t            dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_req    = 0;
  logic req_q  = 1'b0;
  logic [7:0] exp_q[$];

  bit                auto_en   = 1'b0;
  int                rsp_state = 0;
  int                rsp_wait  = 0;
  logic [SDRAMW-1:0] rsp_addr  = '0;

  jtframe_mcu_romrsp #(.ROMW(ROMW), .SDRAMW(SDRAMW), .OFFSET(OFFSET)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rom_cs     (rom_cs),
    .i_rom_addr   (rom_addr),
    .o_rom_data   (rom_data),
    .o_rom_ok     (rom_ok),
    .o_sdram_req  (sdram_req),
    .o_sdram_addr (sdram_addr),
    .i_sdram_ack  (sdram_ack),
    .i_sdram_dst  (sdram_dst),
    .i_sdram_data (sdram_data),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // counts new SDRAM requests (rising edges of sdram_req)
  always @(posedge clk) begin
    req_q <= sdram_req;
    if (sdram_req && !req_q) n_req <= n_req + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SDRAMW-1:0] exp_addr(input logic [ROMW-3:0] tag);
    logic [SDRAMW-1:0] a;
    a = OFFSET + {{(SDRAMW-ROMW+2){1'b0}}, tag};
    return a;
  endfunction

  function automatic logic [31:0] model_word(input logic [SDRAMW-1:0] a);
    return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'h5A, a[21:14], a[7:0] + 8'h11};
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] s);
    logic [31:0] t;
    t = w >> {s, 3'b000};
    return t[7:0];
  endfunction

  // SDRAM responder: random ack delay, random data delay (0 = same cycle as ack)
  task automatic serve_cycle();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    if (rsp_state == 0 && sdram_req) begin
      rsp_addr  = sdram_addr;
      rsp_wait  = $urandom_range(0, 3);
      rsp_state = 1;
    end
    if (rsp_state == 1) begin
      if (rsp_wait == 0) begin
        sdram_ack = 1'b1;
        rsp_wait  = $urandom_range(0, 3);
        rsp_state = 2;
        if (rsp_wait == 0) begin
          sdram_dst  = 1'b1;
          sdram_data = model_word(rsp_addr);
          rsp_state  = 0;
        end
      end else begin
        rsp_wait--;
      end
    end else if (rsp_state == 2) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        sdram_dst  = 1'b1;
        sdram_data = model_word(rsp_addr);
        rsp_state  = 0;
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_en) serve_cycle();
  endtask

  task automatic drive_fetch(input logic [ROMW-1:0] a, input logic [7:0] e);
    rom_cs   = 1'b1;
    rom_addr = a;
    exp_q.push_back(e);
  endtask

  task automatic wait_ok(input string tag, input int max_cycles);
    logic [7:0] e;
    bit seen;
    seen = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (rom_ok) begin
        seen = 1'b1;
        check(tag, rom_data, e);
        break;
      end
      if (i < max_cycles - 1) tick();
    end
    if (!seen) check({tag, "_timeout"}, seen, 1);
  endtask

  task automatic wait_req(input string tag, input logic [SDRAMW-1:0] ea, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (sdram_req) begin
        seen = 1'b1;
        check(tag, sdram_addr, ea);
        break;
      end
      tick();
    end
    if (!seen) check({tag, "_timeout"}, seen, 1);
  endtask

  initial begin
    logic [31:0]     w;
    logic [ROMW-1:0] a;
    logic [ROMW-3:0] tg, line_tag;
    bit              line_valid;
    int              base, exp_reqs;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", sdram_req, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_ok", rom_ok, 0);
    check("rst_data", rom_data, 0);
    check("rst_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b0;

`ifndef JTFRAME_MCU_ROMRSP_PREFETCH_EN
    // first miss at the top of the ROM: address wraps modulo 2^SDRAMW
    rom_cs = 1'b1;
    rom_addr = 12'hFFC;
    @(negedge clk);
    check("t1_ok_c0", rom_ok, 0);
    tick();
    @(negedge clk);
    check("t1_req", sdram_req, 1);
    check("t1_addr", sdram_addr, exp_addr(10'h3FF));
    check("t1_ok", rom_ok, 0);

    // ack at t, data at t+3, rom_ok at t+4
    tick(); sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0;
    @(negedge clk);
    check("t2_req_drop", sdram_req, 0);
    check("t2_wait", dbg_state, ST_WAIT);
    tick();
    tick(); sdram_dst = 1'b1; sdram_data = 32'h44332211; exp_q.push_back(8'h11);
    @(negedge clk);
    check("t2_ok_early", rom_ok, 0);
    tick(); sdram_dst = 1'b0;
    wait_ok("t2_b0", 1);
    w = 32'h44332211;
    for (int i = 1; i < 4; i++) begin
      tick();
      drive_fetch(ROMW'(12'hFFC + i), get_byte(w, 2'(i)));
      wait_ok("t2_bn", 1);
      check("t2_noreq", sdram_req, 0);
    end

    // miss to 000, address moves during WAIT: fill for 000 still lands
    tick(); rom_addr = 12'h000;
    @(negedge clk);
    check("t3_hold", rom_data, 8'h44);
    check("t3_ok0", rom_ok, 0);
    tick();
    @(negedge clk);
    check("t3_req", sdram_req, 1);
    check("t3_addr", sdram_addr, exp_addr(10'h000));
    tick(); sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0; rom_addr = 12'h100;
    tick(); sdram_dst = 1'b1; sdram_data = 32'hDEADBEEF;
    tick(); sdram_dst = 1'b0;
    @(negedge clk);
    check("t3_ok_100", rom_ok, 0);
    check("t3_idle", dbg_state, ST_IDLE);
    #1 rom_addr = 12'h000;
    #1 check("t3_fill_ok", rom_ok, 1);
    check("t3_fill_data", rom_data, 8'hEF);
    rom_addr = 12'h100;
    tick();
    @(negedge clk);
    check("t3_req2", sdram_req, 1);
    check("t3_addr2", sdram_addr, exp_addr(10'h040));

    // same-cycle ack and data
    tick(); sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 32'hA5A5A5A5;
    exp_q.push_back(8'hA5);
    tick(); sdram_ack = 1'b0; sdram_dst = 1'b0;
    wait_ok("t5_byte", 1);
    check("t5_reqcount", n_req, 3);

    // reset while waiting for data; late data pulse is ignored
    tick(); rom_addr = 12'h200;
    tick();
    @(negedge clk);
    check("t4_addr", sdram_addr, exp_addr(10'h080));
    tick(); sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0;
    @(negedge clk);
    check("t4_wait", dbg_state, ST_WAIT);
    tick(); rst = 1'b1;
    @(negedge clk);
    check("t4_rst_req", sdram_req, 0);
    check("t4_rst_state", dbg_state, ST_IDLE);
    check("t4_rst_ok", rom_ok, 0);
    check("t4_rst_data", rom_data, 0);
    tick(); rom_cs = 1'b0; rst = 1'b0;
    tick(); sdram_dst = 1'b1; sdram_data = 32'h12345678;
    tick(); sdram_dst = 1'b0; rom_cs = 1'b1; rom_addr = 12'h200;
    @(negedge clk);
    check("t4_nofill_ok", rom_ok, 0);
    check("t4_nofill_data", rom_data, 0);
    check("t4_nofill_req", sdram_req, 0);
    check("t4_nofill_state", dbg_state, ST_IDLE);
    tick(); rst = 1'b1; rom_cs = 1'b0;
    tick(); rst = 1'b0;
`else
    // demand fill of 3FE triggers prefetch of 3FF; hit there promotes and
    // prefetches 000 (wrap)
    rom_cs = 1'b1;
    rom_addr = 12'hFF8;
    wait_req("t6_req_dem", exp_addr(10'h3FE), 5);
    sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 32'h0D0C0B0A;
    exp_q.push_back(8'h0A);
    tick(); sdram_ack = 1'b0; sdram_dst = 1'b0;
    wait_ok("t6_dem", 1);
    wait_req("t6_req_pf", exp_addr(10'h3FF), 5);
    sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 32'h1D1C1B1A;
    tick(); sdram_ack = 1'b0; sdram_dst = 1'b0;
    drive_fetch(12'hFFC, 8'h1A);
    wait_ok("t6_pf_hit", 1);
    wait_req("t6_req_wrap", exp_addr(10'h000), 5);
    sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 32'h2D2C2B2A;
    tick(); sdram_ack = 1'b0; sdram_dst = 1'b0;
    drive_fetch(12'hFFF, 8'h1D);
    wait_ok("t6_main", 1);
    tick(); rst = 1'b1; rom_cs = 1'b0;
    tick(); rst = 1'b0;
`endif

    // random fetch stream, half sequential
    auto_en    = 1'b1;
    rsp_state  = 0;
    line_valid = 1'b0;
    line_tag   = '0;
    exp_reqs   = 0;
    base       = n_req;
    a          = 12'h7F0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if ($urandom_range(0, 1) == 1) a = a + 1'b1;
      else a = ROMW'($urandom_range(0, 4095));
      tg = a[ROMW-1:2];
      if (!line_valid || line_tag != tg) exp_reqs++;
      line_valid = 1'b1;
      line_tag   = tg;
      w = model_word(exp_addr(tg));
      drive_fetch(a, get_byte(w, a[1:0]));
      wait_ok("rnd_byte", 40);
    end
    tick(); rom_cs = 1'b0;
    repeat (12) tick();
`ifndef JTFRAME_MCU_ROMRSP_PREFETCH_EN
    check("rnd_reqs", n_req - base, exp_reqs);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
